// File: rtl/riscv_mc_pkg.sv
// Shared constants for the multicycle RISC-V control path.
// Holds the state encoding, opcodes, datapath select encodings and the control bundle.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_ALUWB,
    S_BEQ
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp pairs written as {alu_op0, alu_op1}.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_instr;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_main_control_outputs.sv
// Moore output decode: state (plus mem_ready/zero where the state gates on them)
// to the full datapath control bundle. Purely combinational.
module mc_control_outputs
  import riscv_mc_pkg::*;
(
  input  state_e     i_state,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output ctrl_t      o_ctrl
);

  logic w_pc_update;
  logic w_branch;

  always_comb begin
    o_ctrl      = '0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.ir_write   = i_mem_ready;
        o_ctrl.alu_src_a  = SRCA_PC;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALU;
        o_ctrl.alu_op     = ALUOP_ADD;
        w_pc_update       = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a     = SRCA_OLDPC;
        o_ctrl.alu_src_b     = SRCB_IMM;
        o_ctrl.illegal_instr = !is_legal(i_opcode);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = SRCA_RS1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        o_ctrl.adr_src    = 1'b1;
        o_ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        o_ctrl.result_src = RES_RDATA;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        // Strobe and address stay up through every wait cycle.
        o_ctrl.adr_src    = 1'b1;
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXECUTER: begin
        o_ctrl.alu_src_a = SRCA_RS1;
        o_ctrl.alu_src_b = SRCB_RS2;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a  = SRCA_RS1;
        o_ctrl.alu_src_b  = SRCB_RS2;
        o_ctrl.alu_op     = ALUOP_SUB;
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.instr_done = 1'b1;
        w_branch          = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
    o_ctrl.pc_write = w_pc_update | (w_branch & i_zero);
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RISC-V datapath (R, lw, sw, beq).
// Memory handshake: an access completes in the cycle mem_ready is high; the FSM holds until then.
module multicycle_main_control
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op0,
  output logic       alu_op1,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] dbg_state
);

  state_e r_state;
  state_e w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD :
                           (opcode == OP_SW) ? S_MEMWRITE : S_FETCH;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  mc_control_outputs u_outputs (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .i_zero      (zero),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign adr_src       = w_ctrl.adr_src;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign reg_write     = w_ctrl.reg_write;
  assign result_src    = w_ctrl.result_src;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op0       = w_ctrl.alu_op[1];
  assign alu_op1       = w_ctrl.alu_op[0];
  assign instr_done    = w_ctrl.instr_done;
  assign illegal_instr = w_ctrl.illegal_instr;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed instruction table, hand-written corner
// sequences, and a random instruction stream checked cycle by cycle against a plan model.
module tb_multicycle_main_control;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic       alu_op0, alu_op1, instr_done, illegal_instr;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op0       (alu_op0),
    .alu_op1       (alu_op1),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr),
    .dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0] op;
    logic       mr;
    logic       z;
  } stim_t;

  stim_t       stim_q[$];
  logic [14:0] exp_q[$];

  typedef struct {
    logic [6:0] op;
    logic       z;
    int         cycles;
    int         n_rw;
    int         n_mw;
    int         n_pcw;
  } vec_t;

  vec_t vecs[7];

  // Packed as {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
  // alu_src_a, alu_src_b, alu_op0, alu_op1, instr_done, illegal_instr}.
  function automatic logic [14:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic a0, input logic a1, input logic done,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, a0, a1, done, ill};
  endfunction

  function automatic logic [14:0] act_vec();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_op0, alu_op1, instr_done, illegal_instr};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push(input logic [6:0] op, input logic mr, input logic z, input logic [14:0] e);
    stim_t s;
    s.op = op; s.mr = mr; s.z = z;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Behavioural plan: every cycle of one instruction, derived from what each phase should do.
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    logic legal;
    legal = (op == T_R) || (op == T_LW) || (op == T_SW) || (op == T_BEQ);
    for (int i = 0; i < fw; i++) push(op, 1'b0, rnd(), mk(0,0,0,0,0,2'b10,2'b00,2'b10,0,0,0,0));
    push(op, 1'b1, rnd(), mk(1,0,0,1,0,2'b10,2'b00,2'b10,0,0,0,0));
    push(op, rnd(), rnd(), mk(0,0,0,0,0,2'b00,2'b01,2'b01,0,0,0,!legal));
    if (op == T_LW || op == T_SW)
      push(op, rnd(), rnd(), mk(0,0,0,0,0,2'b00,2'b10,2'b01,0,0,0,0));
    if (op == T_LW) begin
      for (int i = 0; i < mw; i++) push(op, 1'b0, rnd(), mk(0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0));
      push(op, 1'b1, rnd(), mk(0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0));
      push(op, rnd(), rnd(), mk(0,0,0,0,1,2'b01,2'b00,2'b00,0,0,1,0));
    end else if (op == T_SW) begin
      for (int i = 0; i < mw; i++) push(op, 1'b0, rnd(), mk(0,1,1,0,0,2'b00,2'b00,2'b00,0,0,0,0));
      push(op, 1'b1, rnd(), mk(0,1,1,0,0,2'b00,2'b00,2'b00,0,0,1,0));
    end else if (op == T_R) begin
      push(op, rnd(), rnd(), mk(0,0,0,0,0,2'b00,2'b10,2'b00,1,0,0,0));
      push(op, rnd(), rnd(), mk(0,0,0,0,1,2'b00,2'b00,2'b00,0,0,1,0));
    end else if (op == T_BEQ) begin
      push(op, rnd(), z, mk(z,0,0,0,0,2'b00,2'b10,2'b00,0,1,1,0));
    end
  endtask

  task automatic run_plan();
    stim_t       s;
    logic [14:0] e;
    int          idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      opcode = s.op; mem_ready = s.mr; zero = s.z;
      #1 chk($sformatf("plan_cycle_%0d", idx), 32'(act_vec()), 32'(e));
      idx++;
    end
  endtask

  task automatic run_count(input vec_t v, input int k);
    int  cyc = 0, rw = 0, mw = 0, pcw = 0;
    logic done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      opcode = v.op; mem_ready = 1'b1; zero = v.z;
      #1;
      cyc++;
      rw  += int'(reg_write);
      mw  += int'(mem_write);
      pcw += int'(pc_write);
      done = instr_done | illegal_instr;
    end
    chk($sformatf("vec%0d_finished", k), 32'(done), 32'd1);
    chk($sformatf("vec%0d_cycles", k), cyc, v.cycles);
    chk($sformatf("vec%0d_reg_writes", k), rw, v.n_rw);
    chk($sformatf("vec%0d_mem_writes", k), mw, v.n_mw);
    chk($sformatf("vec%0d_pc_writes", k), pcw, v.n_pcw);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{T_LW,    1'b0, 5, 1, 0, 1};
    vecs[1] = '{T_SW,    1'b0, 4, 0, 1, 1};
    vecs[2] = '{T_R,     1'b0, 4, 1, 0, 1};
    vecs[3] = '{T_BEQ,   1'b1, 3, 0, 0, 2};
    vecs[4] = '{T_BEQ,   1'b0, 3, 0, 0, 1};
    vecs[5] = '{7'h7f,   1'b0, 2, 0, 0, 1};
    vecs[6] = '{7'h13,   1'b1, 2, 0, 0, 1};

    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = T_LW;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1 chk("reset_fetch_ready", 32'(act_vec()), 32'(mk(1,0,0,1,0,2'b10,2'b00,2'b10,0,0,0,0)));
    mem_ready = 1'b0;
    #1 chk("reset_fetch_wait", 32'(act_vec()), 32'(mk(0,0,0,0,0,2'b10,2'b00,2'b10,0,0,0,0)));
    mem_ready = 1'b1;
    @(negedge clk);
    #1 chk("reset_then_decode", 32'(act_vec()), 32'(mk(0,0,0,0,0,2'b00,2'b01,2'b01,0,0,0,0)));

    for (int k = 0; k < 7; k++) begin
      do_reset();
      run_count(vecs[k], k);
    end

    // Reset during MEMREAD, with mem_ready high so a missed reset would reach MEMWB.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = T_LW; mem_ready = 1'b1; zero = 1'b0;
    end
    @(negedge clk);
    mem_ready = 1'b1; reset = 1'b1;
    #1 chk("abort_in_memread", 32'(adr_src), 32'd1);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1 chk("abort_back_to_fetch", 32'(act_vec()), 32'(mk(0,0,0,0,0,2'b10,2'b00,2'b10,0,0,0,0)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("abort_no_regwrite_%0d", i), 32'(reg_write), 32'd0);
    end

    // Store with three memory wait cycles, then a random instruction stream.
    do_reset();
    add_instr(T_SW, 0, 3, 1'b0);
    add_instr(T_BEQ, 1, 0, 1'b1);
    add_instr(T_BEQ, 0, 0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 4))
        0: op = T_R;
        1: op = T_LW;
        2: op = T_SW;
        3: op = T_BEQ;
        default: op = 7'($urandom);
      endcase
      add_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rnd());
    end
    run_plan();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
